// File: rtl/alu_result_queue.sv
// Registered result queue behind the shift ALU: captures {result, opcode} into a
// DEPTH-entry FIFO with valid/ready on both sides. Optional head flags: `ALU_RESULT_FLAGS_EN.
module alu_result_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_opcode,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_result [DEPTH];
  logic [3:0]       mem_opcode [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             push;
  logic             pop;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      mem_result <= '{default: '0};
      mem_opcode <= '{default: '0};
    end else begin
      if (push) begin
        mem_result[wp] <= in_result;
        mem_opcode[wp] <= in_opcode;
        wp             <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_result = mem_result[rp];
  assign out_opcode = mem_opcode[rp];

`ifdef ALU_RESULT_FLAGS_EN
  logic mem_zero [DEPTH];
  logic mem_neg  [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_zero <= '{default: 1'b0};
      mem_neg  <= '{default: 1'b0};
    end else if (push) begin
      mem_zero[wp] <= (in_result == '0);
      mem_neg[wp]  <= in_result[WIDTH-1];
    end
  end

  assign out_zero = mem_zero[rp];
  assign out_neg  = mem_neg[rp];
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif

endmodule
